cla_pipe_addsub: RTL
====================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. It is the datapath-width successor to our single-cycle 4-bit CLA adder. The block slices a WIDTH-bit add/sub into STAGE_BITS-wide pipeline stages and carries the group carry between stages through registers. A valid/ready handshake on both sides gives full throughput and lossless backpressure, so the block drops straight into the ALU execute pipeline.

## Interface
- WIDTH, 16: operand width; multiple of 4 and of STAGE_BITS.
- STAGE_BITS, 4: bits resolved per pipeline stage; multiple of 4; divides WIDTH. Number of stages L = WIDTH/STAGE_BITS.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- Effective operands: b_eff = b ^ {WIDTH{sub}}, c_eff = cin ^ sub. So sub=1, cin=0 gives a − b, and sub=1, cin=1 gives a − b − 1.
- Stage k (0..L−1) resolves bits [k*STAGE_BITS +: STAGE_BITS] with 4-bit generate/propagate groups.
  - Carry inside a group is full lookahead: C[i+1] = G[i] | P[i]&C[i], expanded.
  - Carry between groups in the same stage ripples group to group.
  - The stage carry-in is the registered carry from stage k−1, or c_eff for stage 0.
- Operand slices above stage k travel skewed through the pipeline. Completed sum slices below stage k travel forward with the beat. Each beat is self-contained, and no beat observes another beat's carry.
- ovf = carry into MSB XOR carry out of MSB. zero = ~|sum. Both are computed in the final stage.
- Every stage has a valid bit. Bubbles propagate as invalid slots, and data in invalid slots is don't-care.
- Global advance = !out_valid | out_ready. in_ready = advance & rst_n. All stage registers, valid bits included, load only when advance=1.
- A beat is accepted on in_valid & in_ready. A result transfers on out_valid & out_ready.

## Timing
- Latency: a beat accepted at edge t presents on out_valid at edge t+L, provided no stall intervenes. Each stalled cycle adds one.
- STAGE_BITS = WIDTH gives L = 1, which is a registered single-cycle CLA.
- Throughput is one beat per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, the whole pipeline freezes.
  - sum, cout, ovf, zero and out_valid hold stable.
  - in_ready=0 in the same cycle, and no beat is lost or duplicated.
- Simultaneous accept and transfer in one cycle is legal and sustains full rate.
- Reset, while rst_n=0 at an edge:
  - all valid bits clear; out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=0 during the reset cycle and rises in the first cycle after rst_n=1.
- Reset mid-operation flushes in-flight beats. None emerge after reset.
- Output changes only on clk edges. in_ready is combinational from out_valid/out_ready/rst_n. There is no other combinational input-to-output path.

## Configuration
- CLA_PIPE_FLAGS_EN defined: ovf and zero are computed as above and registered with sum.
- CLA_PIPE_FLAGS_EN undefined:
  - the ovf/zero logic and registers are removed.
  - the ports still exist and are tied to 0.
  - sum, cout, handshake and latency are unchanged.

## Test plan
All cases use WIDTH=16, STAGE_BITS=4 (L=4) unless stated.
- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 → 4 cycles later sum=0x0000, cout=1, ovf=0, zero=1.
- Subtract with borrow: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0, zero=0.
- Signed overflow: a=0x7FFF, b=0x0001, add → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x0001, sub → sum=0x7FFF, ovf=1.
- Backpressure: stream 8 beats (a=i, b=i, i=1..8) back-to-back, and drop out_ready for cycles 6–9.
  - Required: in_ready=0 exactly while out_valid & !out_ready.
  - Outputs arrive as 2,4,…,16 in order, with no loss or duplicate.
- Reset mid-flight: accept 3 beats, assert rst_n=0 for one cycle, release.
  - Required: out_valid never rises for those beats; in_ready returns to 1 the cycle after release.
  - A new beat 0x1234+0x4321 yields 0x5555 at L cycles.
- Configuration sweep:
  - STAGE_BITS=16 (L=1): 0x00FF+0x0F01 → 0x1000 one cycle after accept.
  - Rebuild without CLA_PIPE_FLAGS_EN: the same overflow case gives ovf=0, zero=0 and an identical sum/cout.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves STAGE_BITS using 4-bit lookahead groups.
// Optional flags: define CLA_PIPE_FLAGS_EN to compute ovf/zero; otherwise those ports are tied to 0.
module cla_pipe_addsub #(
  parameter int WIDTH      = 16,
  parameter int STAGE_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int L  = WIDTH / STAGE_BITS;
  localparam int NG = STAGE_BITS / 4;

  // Full lookahead across one 4-bit group; returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic             w_adv;
  // Per-stage inputs; index L of the valid/carry/sum chains is the output register.
  logic [WIDTH-1:0] w_a_in [L];
  logic [WIDTH-1:0] w_b_in [L];
  logic             w_v_in [L+1];
  logic             w_c_in [L+1];
  logic [WIDTH-1:0] w_s_in [L+1];

  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv & rst_n;

  assign w_a_in[0] = a;
  assign w_b_in[0] = b ^ {WIDTH{sub}};
  assign w_c_in[0] = cin ^ sub;
  assign w_v_in[0] = in_valid;
  assign w_s_in[0] = '0;

  assign out_valid = w_v_in[L];
  assign sum       = w_s_in[L];
  assign cout      = w_c_in[L];

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int LO = k * STAGE_BITS;

    logic [STAGE_BITS-1:0] w_sl;
    logic                  w_co;
    logic [WIDTH-1:0]      w_s_nx;
    logic                  r_vld;
    logic                  r_c;
    logic [WIDTH-1:0]      r_sum;

    // Operands arrive right-justified, so this stage always works on bits [STAGE_BITS-1:0].
    always_comb begin
      logic [4:0] grp;
      logic       c;
      grp  = '0;
      c    = w_c_in[k];
      w_sl = '0;
      for (int gi = 0; gi < NG; gi++) begin
        grp               = cla4(w_a_in[k][4*gi +: 4], w_b_in[k][4*gi +: 4], c);
        w_sl[4*gi +: 4]   = grp[3:0];
        c                 = grp[4];
      end
      w_co                      = c;
      w_s_nx                    = w_s_in[k];
      w_s_nx[LO +: STAGE_BITS]  = w_sl;
    end

    // NOTE: reset is synchronous, so it sits inside the clocked block and overrides the advance enable.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_v_in[k];
        r_c   <= w_co;
        r_sum <= w_s_nx;
      end
    end

    assign w_v_in[k+1] = r_vld;
    assign w_c_in[k+1] = r_c;
    assign w_s_in[k+1] = r_sum;

    if (k < L-1) begin : g_fwd
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      // NOTE: operand registers have no reset; their contents are don't-care while the slot is invalid.
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a <= w_a_in[k] >> STAGE_BITS;
          r_b <= w_b_in[k] >> STAGE_BITS;
        end
      end

      assign w_a_in[k+1] = r_a;
      assign w_b_in[k+1] = r_b;
    end

`ifdef CLA_PIPE_FLAGS_EN
    if (k == L-1) begin : g_flags
      logic r_ovf;
      logic r_zero;

      // a^b^s at the MSB recovers the carry into the MSB.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_ovf  <= w_a_in[k][STAGE_BITS-1] ^ w_b_in[k][STAGE_BITS-1] ^ w_sl[STAGE_BITS-1] ^ w_co;
          r_zero <= ~|w_s_nx;
        end
      end

      assign ovf  = r_ovf;
      assign zero = r_zero;
    end
`endif
  end

`ifndef CLA_PIPE_FLAGS_EN
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule
